// File: rtl/bank_biu_linefill.sv
// Linefill bus interface unit.
// Queues HTU linefill requests and issues them as two-beat AXI read bursts.
// Incoming R beats are assembled into 256-bit lines and handed to the ISU.
module bank_biu_linefill #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         htu_lf_valid_i,
  output logic         htu_lf_ready_o,
  input  logic [2:0]   htu_lf_set_i,
  input  logic [2:0]   htu_lf_way_i,
  input  logic [31:0]  htu_lf_addr_i,
  output logic         axi_arvalid_o,
  input  logic         axi_arready_i,
  output logic [31:0]  axi_araddr_o,
  output logic [5:0]   axi_arid_o,
  output logic [7:0]   axi_arlen_o,
  output logic [2:0]   axi_arsize_o,
  input  logic         axi_rvalid_i,
  output logic         axi_rready_o,
  input  logic [127:0] axi_rdata_i,
  input  logic [5:0]   axi_rid_i,
  input  logic         axi_rlast_i,
  input  logic [1:0]   axi_rresp_i,
  output logic         biu_isu_rvalid_o,
  input  logic         biu_isu_rready_i,
  output logic [255:0] biu_isu_rdata_o,
  output logic [5:0]   biu_isu_rid_o,
  output logic         err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  typedef enum logic [1:0] {R_BEAT0, R_BEAT1, R_OUT} r_state_t;

  typedef struct packed {
    logic [26:0] line;
    logic [5:0]  id;
  } ar_entry_t;

  // ---------------------------------------------------------------------------
  // AR request queue
  // ---------------------------------------------------------------------------
  ar_entry_t   mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        q_empty;
  logic        q_full;
  logic        push;
  logic        pop;
  ar_entry_t   head;
  ar_entry_t   entry_in;
  logic [3:0]  outst_cnt;
  logic        isu_hs;

  assign q_empty  = (wr_ptr == rd_ptr);
  assign q_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gated with reset so the HTU sees no acceptance while the block is held.
  assign htu_lf_ready_o = rst_i & ~q_full & (outst_cnt < MAX_CNT);
  assign push     = htu_lf_valid_i & htu_lf_ready_o;
  assign pop      = axi_arvalid_o & axi_arready_i;
  assign entry_in = '{line: htu_lf_addr_i[31:5], id: {htu_lf_set_i, htu_lf_way_i}};

  // Offset bits of the request address are dropped by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^htu_lf_addr_i[4:0];

  // Queue storage write; the head slot never changes while it is being offered.
  // NOTE: storage has no reset -- validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry_in;
  end

  // Queue pointers with an extra wrap bit for full/empty detection.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign axi_arvalid_o = ~q_empty;
  assign axi_araddr_o  = {head.line, 5'b0};
  assign axi_arid_o    = head.id;
  assign axi_arlen_o   = 8'd1;
  assign axi_arsize_o  = 3'd4;

  // ---------------------------------------------------------------------------
  // Outstanding linefill counter
  // ---------------------------------------------------------------------------
  assign isu_hs = biu_isu_rvalid_o & biu_isu_rready_i;

  // Count accepted requests until their line is handed to the ISU; saturate at 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      outst_cnt <= '0;
    end else if (push && !isu_hs) begin
      outst_cnt <= outst_cnt + 4'd1;
    end else if (!push && isu_hs && (outst_cnt != 4'd0)) begin
      outst_cnt <= outst_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // R beat assembly
  // ---------------------------------------------------------------------------
  r_state_t       state;
  r_state_t       state_nxt;
  logic [255:0]   line_q;
  logic [5:0]     rid_q;
  logic           beat_hs;
  logic           beat_err;

  // Assembly state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= R_BEAT0;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs of the assembly FSM.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt        = state;
    axi_rready_o     = 1'b0;
    biu_isu_rvalid_o = 1'b0;
    case (state)
      R_BEAT0: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) state_nxt = R_BEAT1;
      end
      R_BEAT1: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) state_nxt = R_OUT;
      end
      R_OUT: begin
        biu_isu_rvalid_o = 1'b1;
        if (biu_isu_rready_i) state_nxt = R_BEAT0;
      end
      default: state_nxt = R_BEAT0;
    endcase
  end

  assign beat_hs = axi_rvalid_i & axi_rready_o;

  // Capture beat data: low half with the id on beat 0, high half on beat 1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      line_q <= '0;
      rid_q  <= '0;
    end else if (beat_hs) begin
      if (state == R_BEAT0) begin
        line_q[127:0] <= axi_rdata_i;
        rid_q         <= axi_rid_i;
      end else begin
        line_q[255:128] <= axi_rdata_i;
      end
    end
  end

  assign biu_isu_rdata_o = line_q;
  assign biu_isu_rid_o   = rid_q;

  // Protocol violations on a beat; the line is still delivered.
  assign beat_err = beat_hs &&
                    ((axi_rresp_i != 2'b00) ||
                     ((state == R_BEAT0) && axi_rlast_i) ||
                     ((state == R_BEAT1) && (!axi_rlast_i || (axi_rid_i != rid_q))));

  // Sticky error flag: beat violations or an ISU handshake with nothing in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (beat_err || (isu_hs && (outst_cnt == 4'd0))) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_biu_linefill.sv
// Self-checking bench for bank_biu_linefill: AR and line scoreboards plus
// directed checks of reset, backpressure, limits, stalls and error cases.
module tb_bank_biu_linefill;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         htu_lf_valid_i;
  logic         htu_lf_ready_o;
  logic [2:0]   htu_lf_set_i;
  logic [2:0]   htu_lf_way_i;
  logic [31:0]  htu_lf_addr_i;
  logic         axi_arvalid_o;
  logic         axi_arready_i;
  logic [31:0]  axi_araddr_o;
  logic [5:0]   axi_arid_o;
  logic [7:0]   axi_arlen_o;
  logic [2:0]   axi_arsize_o;
  logic         axi_rvalid_i;
  logic         axi_rready_o;
  logic [127:0] axi_rdata_i;
  logic [5:0]   axi_rid_i;
  logic         axi_rlast_i;
  logic [1:0]   axi_rresp_i;
  logic         biu_isu_rvalid_o;
  logic         biu_isu_rready_i;
  logic [255:0] biu_isu_rdata_o;
  logic [5:0]   biu_isu_rid_o;
  logic         err_o;

  bank_biu_linefill #(.FIFO_DEPTH(4), .MAX_OUTST(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .htu_lf_valid_i(htu_lf_valid_i), .htu_lf_ready_o(htu_lf_ready_o),
    .htu_lf_set_i(htu_lf_set_i), .htu_lf_way_i(htu_lf_way_i),
    .htu_lf_addr_i(htu_lf_addr_i),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arsize_o(axi_arsize_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rid_i(axi_rid_i),
    .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i),
    .biu_isu_rvalid_o(biu_isu_rvalid_o), .biu_isu_rready_i(biu_isu_rready_i),
    .biu_isu_rdata_o(biu_isu_rdata_o), .biu_isu_rid_o(biu_isu_rid_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  id;
  } ar_exp_t;

  typedef struct packed {
    logic [255:0] data;
    logic [5:0]   id;
  } line_exp_t;

  ar_exp_t   ar_q[$];
  line_exp_t line_q[$];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  // One clock: inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (axi_arvalid_o && axi_arready_i) begin
        if (ar_q.size() == 0) begin
          check("ar_unexpected", 1, 0);
        end else begin
          ar_exp_t e;
          e = ar_q.pop_front();
          check("araddr", axi_araddr_o, e.addr);
          check("arid", axi_arid_o, e.id);
          check("arlen", axi_arlen_o, 8'd1);
          check("arsize", axi_arsize_o, 3'd4);
        end
      end
      if (biu_isu_rvalid_o && biu_isu_rready_i) begin
        if (line_q.size() == 0) begin
          check("line_unexpected", 1, 0);
        end else begin
          line_exp_t l;
          l = line_q.pop_front();
          check("isu_rdata", biu_isu_rdata_o, l.data);
          check("isu_rid", biu_isu_rid_o, l.id);
        end
      end
    end
  end

  task automatic do_reset();
    rst_i          = 1'b0;
    htu_lf_valid_i = 1'b0;
    axi_rvalid_i   = 1'b0;
    axi_rlast_i    = 1'b0;
    axi_rresp_i    = 2'b00;
    ar_q.delete();
    line_q.delete();
    #1;
    check("rst_ready", htu_lf_ready_o, 0);
    check("rst_arvalid", axi_arvalid_o, 0);
    check("rst_isu_rvalid", biu_isu_rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", biu_isu_rdata_o, 0);
    cyc();
    cyc();
    rst_i = 1'b1;
    #1;
    check("post_rst_ready", htu_lf_ready_o, 1);
    check("post_rst_rready", axi_rready_o, 1);
  endtask

  task automatic send_req(input logic [2:0] set, input logic [2:0] way, input logic [31:0] addr);
    int n = 0;
    while (!htu_lf_ready_o && n < 50) begin
      cyc();
      n++;
    end
    if (!htu_lf_ready_o) begin
      check("req_timeout", 0, 1);
      return;
    end
    htu_lf_valid_i = 1'b1;
    htu_lf_set_i   = set;
    htu_lf_way_i   = way;
    htu_lf_addr_i  = addr;
    ar_q.push_back('{addr: {addr[31:5], 5'b0}, id: {set, way}});
    cyc();
    htu_lf_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] data, input logic [5:0] id,
                           input logic last, input logic [1:0] resp);
    int n = 0;
    axi_rvalid_i = 1'b1;
    axi_rdata_i  = data;
    axi_rid_i    = id;
    axi_rlast_i  = last;
    axi_rresp_i  = resp;
    while (!axi_rready_o && n < 50) begin
      cyc();
      n++;
    end
    if (!axi_rready_o) check("beat_timeout", 0, 1);
    cyc();
    axi_rvalid_i = 1'b0;
    axi_rlast_i  = 1'b0;
    axi_rresp_i  = 2'b00;
  endtask

  task automatic send_line(input logic [5:0] id, input logic [127:0] b0, input logic [127:0] b1);
    send_beat(b0, id, 1'b0, 2'b00);
    line_q.push_back('{data: {b1, b0}, id: id});
    send_beat(b1, id, 1'b1, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    htu_lf_set_i     = '0;
    htu_lf_way_i     = '0;
    htu_lf_addr_i    = '0;
    axi_arready_i    = 1'b1;
    axi_rdata_i      = '0;
    axi_rid_i        = '0;
    biu_isu_rready_i = 1'b1;
    do_reset();

    // Single fill with offset bits set in the request address.
    send_req(3'd3, 3'd5, 32'h1000_0047);
    check("ar_next_cycle", axi_arvalid_o, 1);
    send_beat(pat(8'hAA), 6'h1D, 1'b0, 2'b00);
    line_q.push_back('{data: {pat(8'hBB), pat(8'hAA)}, id: 6'h1D});
    send_beat(pat(8'hBB), 6'h1D, 1'b1, 2'b00);
    check("isu_latency", biu_isu_rvalid_o, 1);
    cyc();
    check("isu_drop", biu_isu_rvalid_o, 0);

    // AR backpressure: fields hold, then the queue fills.
    axi_arready_i = 1'b0;
    send_req(3'd1, 3'd2, 32'h2000_0020);
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", axi_arvalid_o, 1);
      check("bp_araddr", axi_araddr_o, 32'h2000_0020);
      check("bp_arid", axi_arid_o, 6'h0A);
      cyc();
    end
    for (int i = 0; i < 3; i++) send_req(3'(i + 2), 3'(i), 32'h3000_0000 + 32'(i) * 32'h40);
    check("full_ready", htu_lf_ready_o, 0);
    cyc();
    check("full_ready_hold", htu_lf_ready_o, 0);
    axi_arready_i = 1'b1;
    cyc();
    check("pop_ready", htu_lf_ready_o, 1);
    send_req(3'd7, 3'd7, 32'h4000_00E0);
    cyc();
    cyc();
    cyc();
    check("ar_drained", 32'(ar_q.size()), 0);

    // ISU stall on the first returned line with the next beat already waiting.
    biu_isu_rready_i = 1'b0;
    send_beat(pat(8'h11), 6'h0A, 1'b0, 2'b00);
    line_q.push_back('{data: {pat(8'h22), pat(8'h11)}, id: 6'h0A});
    send_beat(pat(8'h22), 6'h0A, 1'b1, 2'b00);
    axi_rvalid_i = 1'b1;
    axi_rdata_i  = pat(8'h33);
    axi_rid_i    = 6'h10;
    for (int i = 0; i < 3; i++) begin
      check("stall_rvalid", biu_isu_rvalid_o, 1);
      check("stall_rready", axi_rready_o, 0);
      check("stall_rdata", biu_isu_rdata_o, {pat(8'h22), pat(8'h11)});
      cyc();
    end
    biu_isu_rready_i = 1'b1;
    cyc();
    cyc();
    axi_rvalid_i = 1'b0;
    line_q.push_back('{data: {pat(8'h44), pat(8'h33)}, id: 6'h10});
    send_beat(pat(8'h44), 6'h10, 1'b1, 2'b00);
    send_line(6'h19, pat(8'h55), pat(8'h66));
    send_line(6'h22, pat(8'h77), pat(8'h88));
    send_line(6'h3F, pat(8'h99), pat(8'hCC));
    cyc();
    check("no_err_normal", err_o, 0);
    check("cnt_zero", dut.outst_cnt, 0);

    // Error: bad response on beat 1, line still delivered, flag sticky.
    send_req(3'd2, 3'd1, 32'h5000_0000);
    send_beat(pat(8'h01), 6'h11, 1'b0, 2'b00);
    check("err_before", err_o, 0);
    line_q.push_back('{data: {pat(8'h02), pat(8'h01)}, id: 6'h11});
    send_beat(pat(8'h02), 6'h11, 1'b1, 2'b10);
    check("err_rresp", err_o, 1);
    check("err_line_valid", biu_isu_rvalid_o, 1);
    cyc();
    cyc();
    check("err_sticky", err_o, 1);

    // Error: rlast on beat 0.
    do_reset();
    send_req(3'd4, 3'd4, 32'h6000_0100);
    send_beat(pat(8'h03), 6'h24, 1'b1, 2'b00);
    check("err_rlast0", err_o, 1);
    line_q.push_back('{data: {pat(8'h04), pat(8'h03)}, id: 6'h24});
    send_beat(pat(8'h04), 6'h24, 1'b1, 2'b00);
    cyc();

    // ISU handshake with nothing outstanding: error, counter stays at 0.
    do_reset();
    send_line(6'h05, pat(8'h0E), pat(8'h0F));
    cyc();
    check("err_underflow", err_o, 1);
    check("underflow_cnt", dut.outst_cnt, 0);
    check("underflow_ready", htu_lf_ready_o, 1);

    // Outstanding limit.
    do_reset();
    for (int i = 0; i < 8; i++) send_req(3'(i), 3'(7 - i), 32'h7000_0000 + 32'(i) * 32'h20);
    check("outst_ready", htu_lf_ready_o, 0);
    cyc();
    check("outst_ready_hold", htu_lf_ready_o, 0);
    send_line(6'h07, pat(8'hD0), pat(8'hD1));
    check("outst_rout_ready", htu_lf_ready_o, 0);
    cyc();
    check("outst_release", htu_lf_ready_o, 1);

    // Reset between beat 0 and beat 1.
    do_reset();
    send_req(3'd6, 3'd2, 32'h8000_0040);
    send_beat(pat(8'hE0), 6'h32, 1'b0, 2'b00);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("midrst_rvalid", biu_isu_rvalid_o, 0);
      cyc();
    end
    check("midrst_cnt", dut.outst_cnt, 0);
    check("midrst_err", err_o, 0);
    send_req(3'd6, 3'd2, 32'h8000_0040);
    send_line(6'h32, pat(8'hF0), pat(8'hF1));
    cyc();
    cyc();

    check("ar_q_empty", 32'(ar_q.size()), 0);
    check("line_q_empty", 32'(line_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
